// File: rtl/io_bus_reg_slave_if.sv
// IO_bus: 32-bit register bus with a four-phase handshake1_1/handshake1_2 handshake.
interface IO_bus;
  logic [7:0]  reg_address;
  logic        RW;
  logic [31:0] data_out;
  logic        handshake1_1;
  logic [31:0] data_in;
  logic        handshake1_2;

  modport master (
    output reg_address, RW, data_out, handshake1_1,
    input  data_in, handshake1_2
  );

  modport slave (
    input  reg_address, RW, data_out, handshake1_1,
    output data_in, handshake1_2
  );
endinterface

// File: rtl/io_bus_reg_slave.sv
// Register-bank slave on IO_bus: read/write config registers followed by read-only status words.
// Idle slaves drive zeros so the top level can OR data_in/handshake1_2 across instances.
module io_bus_reg_slave #(
  parameter logic [7:0]  BASE_ADDRESS = 8'h00,
  parameter int          NUM_CFG      = 4,
  parameter int          NUM_STATUS   = 2,
  parameter logic [31:0] CFG_RESET    = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  IO_bus.slave                     bus,
  output logic [32*NUM_CFG-1:0]    cfg_regs,
  output logic [NUM_CFG-1:0]       cfg_wr_strobe,
  input  logic [(NUM_STATUS > 0 ? 32*NUM_STATUS : 32)-1:0] status_in
);

  localparam int         NUM_REGS = NUM_CFG + NUM_STATUS;
  localparam logic [8:0] WIN_SIZE = 9'(NUM_REGS);

  if (NUM_CFG < 1 || NUM_CFG > 16) begin : g_bad_num_cfg
    $error("io_bus_reg_slave: NUM_CFG must be 1..16");
  end
  if (NUM_STATUS < 0 || NUM_STATUS > 16) begin : g_bad_num_status
    $error("io_bus_reg_slave: NUM_STATUS must be 0..16");
  end
  if (int'(BASE_ADDRESS) + NUM_REGS - 1 > 255) begin : g_bad_window
    $error("io_bus_reg_slave: address window extends past 8'hFF");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } state_e;

  state_e      state_q;
  logic [7:0]  off_q;
  logic        rw_q;
  logic [31:0] wdata_q;
  logic [31:0] data_in_q;
  logic        hs2_q;
  logic [NUM_CFG-1:0] strobe_q;
  logic [31:0] cfg_q [NUM_CFG];

  // 9-bit difference: bit 8 is the borrow, so addresses below the base never wrap into range.
  logic [8:0]  addr_diff;
  logic        req_hit;
  logic [31:0] rd_data;

  always_comb begin
    addr_diff = {1'b0, bus.reg_address} - {1'b0, BASE_ADDRESS};
    req_hit   = !addr_diff[8] && (addr_diff < WIN_SIZE);
    rd_data   = '0;
    for (int i = 0; i < NUM_CFG; i++) begin
      if (off_q == 8'(i)) rd_data = cfg_q[i];
    end
    for (int j = 0; j < NUM_STATUS; j++) begin
      if (off_q == 8'(NUM_CFG + j)) rd_data = status_in[32*j +: 32];
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      off_q     <= '0;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      data_in_q <= '0;
      hs2_q     <= 1'b0;
      strobe_q  <= '0;
      // NOTE: the config array is a handful of flops, not RAM, so it can and must take CFG_RESET.
      for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= CFG_RESET;
    end else begin
      strobe_q <= '0;
      case (state_q)
        IDLE: begin
          if (bus.handshake1_1 && req_hit) begin
            off_q   <= addr_diff[7:0];
            rw_q    <= bus.RW;
            wdata_q <= bus.data_out;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          hs2_q   <= 1'b1;
          state_q <= ACK;
          if (rw_q) begin
            data_in_q <= rd_data;
          end else begin
            // Writes landing on a status offset match no config index and are simply dropped.
            for (int i = 0; i < NUM_CFG; i++) begin
              if (off_q == 8'(i)) begin
                cfg_q[i]    <= wdata_q;
                strobe_q[i] <= 1'b1;
              end
            end
          end
        end
        ACK: begin
          if (!bus.handshake1_1) begin
            hs2_q     <= 1'b0;
            data_in_q <= '0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data_in      = data_in_q;
  assign bus.handshake1_2 = hs2_q;
  assign cfg_wr_strobe    = strobe_q;

  for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_out
    assign cfg_regs[32*g +: 32] = cfg_q[g];
  end

endmodule

// File: tb/tb_io_bus_reg_slave.sv
// Directed bench for io_bus_reg_slave: BASE 8'h10, 4 config + 2 status registers.
module tb_io_bus_reg_slave;

  localparam logic [31:0] CR = 32'hA5A5_0F0F;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] cfg_regs;
  logic [3:0]   cfg_wr_strobe;
  logic [63:0]  status_in;

  int n_checks = 0;
  int n_fail   = 0;

  int          lat;
  logic [31:0] rd;
  logic [3:0]  stb;
  logic        bad;

  IO_bus bus ();

  io_bus_reg_slave #(
    .BASE_ADDRESS (8'h10),
    .NUM_CFG      (4),
    .NUM_STATUS   (2),
    .CFG_RESET    (CR)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .cfg_regs      (cfg_regs),
    .cfg_wr_strobe (cfg_wr_strobe),
    .status_in     (status_in)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full handshake: raise request, wait (bounded) for ack, capture, release, one edge for the drop.
  task automatic txn(input logic [7:0] a, input logic rw, input logic [31:0] wd,
                     output int l, output logic [31:0] r, output logic [3:0] s);
    bus.reg_address  = a;
    bus.RW           = rw;
    bus.data_out     = wd;
    bus.handshake1_1 = 1'b1;
    l = 0;
    do begin
      step();
      l++;
    end while (!bus.handshake1_2 && l < 8);
    r = bus.data_in;
    s = cfg_wr_strobe;
    bus.handshake1_1 = 1'b0;
    step();
  endtask

  initial begin
    reset            = 1'b1;
    bus.reg_address  = '0;
    bus.RW           = 1'b0;
    bus.data_out     = '0;
    bus.handshake1_1 = 1'b0;
    status_in        = {32'h0000_1234, 32'h00AB_CD00};

    #12;
    check("rst_hs2", bus.handshake1_2, 0);
    check("rst_data_in", bus.data_in, 0);
    check("rst_strobe", cfg_wr_strobe, 0);
    check("rst_cfg", cfg_regs, {4{CR}});
    @(negedge clk) reset = 1'b0;
    step();

    // Write/readback
    txn(8'h12, 1'b0, 32'hDEAD_BEEF, lat, rd, stb);
    check("wr_latency", lat, 2);
    check("wr_strobe", stb, 4'b0100);
    check("wr_cfg2", cfg_regs[95:64], 32'hDEAD_BEEF);
    check("wr_rel_hs2", bus.handshake1_2, 0);
    check("wr_rel_strobe", cfg_wr_strobe, 0);
    txn(8'h12, 1'b1, 32'h0, lat, rd, stb);
    check("rd_latency", lat, 2);
    check("rd_data", rd, 32'hDEAD_BEEF);
    check("rd_no_strobe", stb, 0);
    check("rd_rel_data_in", bus.data_in, 0);

    // Status read and write protection
    txn(8'h15, 1'b1, 32'h0, lat, rd, stb);
    check("st1_data", rd, 32'h0000_1234);
    txn(8'h14, 1'b1, 32'h0, lat, rd, stb);
    check("st0_data", rd, 32'h00AB_CD00);
    txn(8'h15, 1'b0, 32'hFFFF_FFFF, lat, rd, stb);
    check("st_wr_acked", lat, 2);
    check("st_wr_strobe", stb, 0);
    check("st_wr_cfg", cfg_regs, {CR, 32'hDEAD_BEEF, CR, CR});

    // Out-of-range silence, just below and just above the window
    bad = 1'b0;
    bus.RW = 1'b0;
    bus.data_out = 32'h1357_9BDF;
    bus.reg_address = 8'h0F;
    bus.handshake1_1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.handshake1_2 !== 1'b0 || bus.data_in !== 32'h0 || cfg_wr_strobe !== 4'h0) bad = 1'b1;
    end
    bus.reg_address = 8'h16;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.handshake1_2 !== 1'b0 || bus.data_in !== 32'h0 || cfg_wr_strobe !== 4'h0) bad = 1'b1;
    end
    bus.handshake1_1 = 1'b0;
    step();
    check("oor_silent", bad, 0);
    check("oor_cfg", cfg_regs, {CR, 32'hDEAD_BEEF, CR, CR});
    txn(8'h10, 1'b1, 32'h0, lat, rd, stb);
    check("oor_then_idle_lat", lat, 2);
    check("oor_then_idle_data", rd, CR);

    // Abort: request dropped right after acceptance
    bus.reg_address  = 8'h10;
    bus.RW           = 1'b0;
    bus.data_out     = 32'h0000_0005;
    bus.handshake1_1 = 1'b1;
    step();
    bus.handshake1_1 = 1'b0;
    step();
    check("abort_hs2_high", bus.handshake1_2, 1);
    check("abort_strobe", cfg_wr_strobe, 4'b0001);
    check("abort_cfg0", cfg_regs[31:0], 32'h0000_0005);
    step();
    check("abort_hs2_pulse", bus.handshake1_2, 0);

    // Reset in the middle of ACK
    bus.reg_address  = 8'h11;
    bus.data_out     = 32'h0000_0077;
    bus.handshake1_1 = 1'b1;
    step();
    step();
    check("mid_hs2", bus.handshake1_2, 1);
    check("mid_strobe", cfg_wr_strobe, 4'b0010);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_hs2", bus.handshake1_2, 0);
    check("mid_rst_data_in", bus.data_in, 0);
    check("mid_rst_strobe", cfg_wr_strobe, 0);
    check("mid_rst_cfg", cfg_regs, {4{CR}});
    bus.handshake1_1 = 1'b0;
    @(negedge clk) reset = 1'b0;
    step();
    txn(8'h13, 1'b0, 32'h0000_CAFE, lat, rd, stb);
    check("post_rst_lat", lat, 2);
    check("post_rst_strobe", stb, 4'b1000);
    check("post_rst_cfg3", cfg_regs[127:96], 32'h0000_CAFE);

    // Back-to-back: request held high must not start a second transaction
    bus.reg_address  = 8'h10;
    bus.data_out     = 32'h1111_1111;
    bus.handshake1_1 = 1'b1;
    step();
    step();
    check("b2b_first_ack", bus.handshake1_2, 1);
    bus.reg_address = 8'h11;
    bus.data_out    = 32'h2222_2222;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.handshake1_2 !== 1'b1 || cfg_wr_strobe !== 4'h0) bad = 1'b1;
    end
    check("b2b_held_single", bad, 0);
    bus.handshake1_1 = 1'b0;
    step();
    check("b2b_release", bus.handshake1_2, 0);
    check("b2b_cfg", cfg_regs, {32'h0000_CAFE, CR, CR, 32'h1111_1111});
    txn(8'h11, 1'b0, 32'h2222_2222, lat, rd, stb);
    check("b2b_second_lat", lat, 2);
    check("b2b_second_strobe", stb, 4'b0010);
    check("b2b_second_cfg1", cfg_regs[63:32], 32'h2222_2222);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
